mem_line_ctrl: RTL and testbench

Cache-line sequencer in front of the byte-wide main memory. Accepts one line read (fill) or line write (writeback) request at a time from the cache, breaks it into LINE_BYTES consecutive single-byte memory accesses, assembles or streams the line, and returns a single-cycle completion pulse. Sits between the cache controller and the `mem` array, and is the only master driving the memory's address, enable and write-data inputs.

---
 rtl/mem_line_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_mem_line_ctrl.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_line_ctrl.sv
// mem_line_ctrl: cache-line sequencer sitting between the cache controller and the
// byte-wide main memory. One line fill or writeback is accepted at a time, split into
// LINE_BYTES single-byte memory accesses, and finished with a one-cycle resp_valid pulse.
// Optional feature: define MEM_LINE_CTRL_CWF_EN for critical-word-first ordering, where
// the byte accesses start at the request offset and wrap around inside the line.
module mem_line_ctrl #(
    parameter int PA_WIDTH   = 20,
    parameter int LINE_BYTES = 16,
    parameter int WIDTH      = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic                        req_we,
    input  logic [PA_WIDTH-1:0]         req_addr,
    input  logic [LINE_BYTES*WIDTH-1:0] req_wdata,
    output logic                        resp_valid,
    output logic [LINE_BYTES*WIDTH-1:0] resp_rdata,
    output logic [PA_WIDTH-1:0]         mem_addr,
    output logic                        mem_rd_en,
    output logic                        mem_wr_en,
    output logic [WIDTH-1:0]            mem_wr_data,
    input  logic [WIDTH-1:0]            mem_rd_data
);

    localparam int OFF_W  = $clog2(LINE_BYTES);
    localparam int TAG_W  = PA_WIDTH - OFF_W;
    localparam int LINE_W = LINE_BYTES * WIDTH;
    localparam logic [OFF_W-1:0] LAST_IDX = OFF_W'(LINE_BYTES - 1);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        DRAIN,
        WRITE,
        RESP
    } state_t;

    state_t              state_q, state_d;
    logic [TAG_W-1:0]    lineTag_q, lineTag_d;
    logic [OFF_W-1:0]    startIdx_q, startIdx_d;
    logic [OFF_W-1:0]    count_q, count_d;
    logic [LINE_W-1:0]   lineBuf_q, lineBuf_d;
    logic [PA_WIDTH-1:0] memAddr_q, memAddr_d;
    logic                memRdEn_q, memRdEn_d;
    logic                memWrEn_q, memWrEn_d;
    logic [WIDTH-1:0]    memWrData_q, memWrData_d;
    logic                respValid_q, respValid_d;
    logic [LINE_W-1:0]   respRdata_q, respRdata_d;

    logic [OFF_W-1:0]    reqStart;
    logic [OFF_W-1:0]    issueIdx;
    logic [OFF_W-1:0]    returnLane;

`ifdef MEM_LINE_CTRL_CWF_EN
    assign reqStart = req_addr[OFF_W-1:0];
`else
    logic unusedReqOffset;
    assign reqStart        = '0;
    assign unusedReqOffset = ^req_addr[OFF_W-1:0];
`endif

    // The counter only says how many bytes have gone out; the byte actually touched is
    // the start index plus that count, which wraps inside the line by construction.
    assign issueIdx = startIdx_q + count_q;

    // A byte returned by memory belongs to the lane of the address strobed last cycle,
    // so the lane follows the registered address rather than the counter.
    assign returnLane = memAddr_q[OFF_W-1:0];

    assign req_ready   = (state_q == IDLE) && !rst;
    assign resp_valid  = respValid_q;
    assign resp_rdata  = respRdata_q;
    assign mem_addr    = memAddr_q;
    assign mem_rd_en   = memRdEn_q;
    assign mem_wr_en   = memWrEn_q;
    assign mem_wr_data = memWrData_q;

    // Next-state and next-output computation for the line sequencer.
    always_comb begin
        state_d     = state_q;
        lineTag_d   = lineTag_q;
        startIdx_d  = startIdx_q;
        count_d     = count_q;
        lineBuf_d   = lineBuf_q;
        memAddr_d   = memAddr_q;
        memRdEn_d   = 1'b0;
        memWrEn_d   = 1'b0;
        memWrData_d = memWrData_q;
        respValid_d = 1'b0;
        respRdata_d = respRdata_q;

        if (memRdEn_q) begin
            lineBuf_d[int'(returnLane)*WIDTH +: WIDTH] = mem_rd_data;
        end

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    lineTag_d  = req_addr[PA_WIDTH-1:OFF_W];
                    startIdx_d = reqStart;
                    if (req_we) begin
                        // The first write byte goes out on the accepting edge so the
                        // whole writeback fits in LINE_BYTES edges.
                        lineBuf_d   = req_wdata;
                        memWrEn_d   = 1'b1;
                        memAddr_d   = {req_addr[PA_WIDTH-1:OFF_W], reqStart};
                        memWrData_d = req_wdata[int'(reqStart)*WIDTH +: WIDTH];
                        count_d     = OFF_W'(1);
                        state_d     = WRITE;
                    end else begin
                        count_d = '0;
                        state_d = READ;
                    end
                end
            end

            READ: begin
                memRdEn_d = 1'b1;
                memAddr_d = {lineTag_q, issueIdx};
                count_d   = count_q + OFF_W'(1);
                if (count_q == LAST_IDX) begin
                    state_d = DRAIN;
                end
            end

            DRAIN: begin
                respRdata_d = lineBuf_d;
                respValid_d = 1'b1;
                state_d     = RESP;
            end

            WRITE: begin
                if (count_q == '0) begin
                    respValid_d = 1'b1;
                    state_d     = RESP;
                end else begin
                    memWrEn_d   = 1'b1;
                    memAddr_d   = {lineTag_q, issueIdx};
                    memWrData_d = lineBuf_q[int'(issueIdx)*WIDTH +: WIDTH];
                    count_d     = count_q + OFF_W'(1);
                end
            end

            RESP: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs; reset aborts any line in flight and clears the read line.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            lineTag_q   <= '0;
            startIdx_q  <= '0;
            count_q     <= '0;
            lineBuf_q   <= '0;
            memAddr_q   <= '0;
            memRdEn_q   <= 1'b0;
            memWrEn_q   <= 1'b0;
            memWrData_q <= '0;
            respValid_q <= 1'b0;
            respRdata_q <= '0;
        end else begin
            state_q     <= state_d;
            lineTag_q   <= lineTag_d;
            startIdx_q  <= startIdx_d;
            count_q     <= count_d;
            lineBuf_q   <= lineBuf_d;
            memAddr_q   <= memAddr_d;
            memRdEn_q   <= memRdEn_d;
            memWrEn_q   <= memWrEn_d;
            memWrData_q <= memWrData_d;
            respValid_q <= respValid_d;
            respRdata_q <= respRdata_d;
        end
    end

endmodule

// File: tb/tb_mem_line_ctrl.sv
// tb_mem_line_ctrl: bench for mem_line_ctrl with a byte-wide memory attached.
// Expected lines, address orders and latencies come from a reference memory and
// simple arithmetic on line base and offset. Honours MEM_LINE_CTRL_CWF_EN.
module tb_mem_line_ctrl;

`ifdef MEM_LINE_CTRL_CWF_EN
    localparam bit CWF = 1'b1;
`else
    localparam bit CWF = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic         req_we = 1'b0;
    logic [19:0]  req_addr = '0;
    logic [127:0] req_wdata = '0;
    logic         resp_valid;
    logic [127:0] resp_rdata;
    logic [19:0]  mem_addr;
    logic         mem_rd_en;
    logic         mem_wr_en;
    logic [7:0]   mem_wr_data;
    logic [7:0]   mem_rd_data;

    logic [7:0]   mem [0:1048575];
    logic         preWe = 1'b0;
    logic [19:0]  preAddr = '0;
    logic [7:0]   preData = '0;

    logic [7:0]   refMem [logic [19:0]];
    logic [127:0] modelRdata = '0;

    int testsRun = 0;
    int testsFailed = 0;
    int edgeCount = 0;
    int readyHighCnt = 0;
    int bothCnt = 0;
    int acceptEdges[$];
    int respEdges[$];
    logic [20:0] logEntry[$];

    mem_line_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .mem_addr   (mem_addr),
        .mem_rd_en  (mem_rd_en),
        .mem_wr_en  (mem_wr_en),
        .mem_wr_data(mem_wr_data),
        .mem_rd_data(mem_rd_data)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Memory: reads return the addressed byte while the strobe is up, writes land on the edge.
    assign mem_rd_data = mem[mem_addr];
    always @(posedge clk) begin
        if (mem_wr_en) mem[mem_addr] <= mem_wr_data;
        if (preWe) mem[preAddr] <= preData;
    end

    // Edge counter used to time acceptances and responses.
    always @(posedge clk) edgeCount <= edgeCount + 1;

    // Mid-cycle monitor: logs acceptances, responses, strobes and ready cycles.
    always @(negedge clk) begin
        if (!rst) begin
            if (req_valid && req_ready) acceptEdges.push_back(edgeCount + 1);
            if (resp_valid) respEdges.push_back(edgeCount);
            if (mem_rd_en || mem_wr_en) logEntry.push_back({mem_wr_en, mem_addr});
            if (mem_rd_en && mem_wr_en) bothCnt <= bothCnt + 1;
            if (req_ready) readyHighCnt <= readyHighCnt + 1;
        end
    end

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        testsRun++;
        assert (obs === exp) else begin
            testsFailed++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] refLine(input logic [19:0] base);
        logic [127:0] l;
        l = '0;
        for (int i = 0; i < 16; i++) l[i*8 +: 8] = refMem[base + 20'(i)];
        return l;
    endfunction

    function automatic logic [127:0] memLine(input logic [19:0] base);
        logic [127:0] l;
        l = '0;
        for (int i = 0; i < 16; i++) l[i*8 +: 8] = mem[base + 20'(i)];
        return l;
    endfunction

    function automatic logic [127:0] randLine();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic preloadLine(input logic [19:0] base, input logic [127:0] data);
        for (int i = 0; i < 16; i++) begin
            preWe   = 1'b1;
            preAddr = base + 20'(i);
            preData = data[i*8 +: 8];
            refMem[base + 20'(i)] = data[i*8 +: 8];
            nextCycle();
        end
        preWe = 1'b0;
    endtask

    task automatic applyStimulus(input logic we, input logic [19:0] addr,
                                 input logic [127:0] wdata, input bit hold);
        int waited;
        bit accepted;
        waited   = 0;
        accepted = 1'b0;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_valid = 1'b1;
        while (!accepted && waited < 200) begin
            @(negedge clk);
            accepted = req_ready && !rst;
            nextCycle();
            waited++;
        end
        if (!hold) req_valid = 1'b0;
        checkOutput("accepted", 128'(accepted), 128'd1);
    endtask

    task automatic waitResp(input int target);
        int waited;
        waited = 0;
        while (respEdges.size() < target && waited < 200) begin
            nextCycle();
            waited++;
        end
        checkOutput("resp_seen", 128'(respEdges.size() >= target), 128'd1);
    endtask

    task automatic runTransaction(input logic we, input logic [19:0] addr, input logic [127:0] wdata);
        int acc0, resp0, log0, lat;
        logic [19:0] base;
        logic [3:0] startOff;
        logic [20:0] expEntry;
        logic [127:0] obsEntry;
        base     = {addr[19:4], 4'h0};
        startOff = CWF ? addr[3:0] : 4'h0;
        acc0  = acceptEdges.size();
        resp0 = respEdges.size();
        log0  = logEntry.size();
        applyStimulus(we, addr, wdata, 1'b0);
        waitResp(resp0 + 1);
        repeat (2) nextCycle();
        checkOutput("resp_count", 128'(respEdges.size() - resp0), 128'd1);
        if (acceptEdges.size() > acc0 && respEdges.size() > resp0)
            lat = respEdges[resp0] - acceptEdges[acc0];
        else
            lat = -1;
        checkOutput(we ? "write_latency" : "read_latency", 128'(lat), we ? 128'd16 : 128'd17);
        checkOutput("strobe_count", 128'(logEntry.size() - log0), 128'd16);
        for (int i = 0; i < 16; i++) begin
            expEntry = {we, base + 20'((int'(startOff) + i) % 16)};
            if (log0 + i < logEntry.size()) obsEntry = 128'(logEntry[log0 + i]);
            else obsEntry = 'x;
            checkOutput($sformatf("strobe_%0d", i), obsEntry, 128'(expEntry));
        end
        if (we) begin
            for (int i = 0; i < 16; i++) refMem[base + 20'(i)] = wdata[i*8 +: 8];
            checkOutput("mem_line", memLine(base), refLine(base));
            checkOutput("rdata_hold", resp_rdata, modelRdata);
        end else begin
            modelRdata = refLine(base);
            checkOutput("read_line", resp_rdata, modelRdata);
        end
    endtask

    // Watchdog so a stuck design still ends the run.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: observed no completion, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed and random sequence.
    initial begin
        logic [127:0] line;
        logic [127:0] expLine;
        logic [19:0] a;
        int acc0, resp0, rdy0, rdyDelta;

        repeat (3) nextCycle();
        checkOutput("reset_req_ready", 128'(req_ready), 128'd0);
        checkOutput("reset_rd_en", 128'(mem_rd_en), 128'd0);
        checkOutput("reset_wr_en", 128'(mem_wr_en), 128'd0);
        checkOutput("reset_addr", 128'(mem_addr), 128'd0);
        checkOutput("reset_wr_data", 128'(mem_wr_data), 128'd0);
        checkOutput("reset_resp_valid", 128'(resp_valid), 128'd0);
        checkOutput("reset_resp_rdata", resp_rdata, 128'd0);
        rst = 1'b0;
        #1;
        checkOutput("ready_after_reset", 128'(req_ready), 128'd1);
        nextCycle();

        // Line fill of 0x00100 with a mid-line request address.
        for (int i = 0; i < 16; i++) line[i*8 +: 8] = 8'(8'hA0 + i);
        preloadLine(20'h00100, line);
        runTransaction(1'b0, 20'h00105, '0);

        // Writeback of 0x00200, then read it back from a random offset.
        for (int i = 0; i < 16; i++) line[i*8 +: 8] = 8'(8'h10 + i);
        runTransaction(1'b1, 20'h00200, line);
        runTransaction(1'b0, {16'h0020, 4'($urandom)}, '0);
        checkOutput("readback", resp_rdata, line);

        // Second request held behind a read of 0x00100.
        acc0  = acceptEdges.size();
        resp0 = respEdges.size();
        applyStimulus(1'b0, 20'h00103, '0, 1'b1);
        rdy0 = readyHighCnt;
        line = randLine();
        applyStimulus(1'b1, 20'h00400, line, 1'b0);
        rdyDelta = readyHighCnt - rdy0;
        waitResp(resp0 + 2);
        repeat (2) nextCycle();
        modelRdata = refLine(20'h00100);
        for (int i = 0; i < 16; i++) refMem[20'h00400 + 20'(i)] = line[i*8 +: 8];
        checkOutput("b2b_resp_count", 128'(respEdges.size() - resp0), 128'd2);
        if (acceptEdges.size() > acc0 + 1 && respEdges.size() > resp0)
            checkOutput("b2b_accept_gap", 128'(acceptEdges[acc0 + 1] - respEdges[resp0]), 128'd2);
        else
            checkOutput("b2b_accept_gap", 128'd0, 128'd2);
        checkOutput("b2b_ready_cycles", 128'(rdyDelta), 128'd1);
        checkOutput("b2b_read_line", resp_rdata, modelRdata);
        checkOutput("b2b_write_line", memLine(20'h00400), refLine(20'h00400));

        // Reset five bytes into a writeback of 0x00300.
        preloadLine(20'h00300, {16{8'hFF}});
        line  = randLine();
        resp0 = respEdges.size();
        applyStimulus(1'b1, 20'h00300, line, 1'b0);
        repeat (4) nextCycle();
        rst = 1'b1;
        nextCycle();
        checkOutput("abort_wr_en", 128'(mem_wr_en), 128'd0);
        checkOutput("abort_rd_en", 128'(mem_rd_en), 128'd0);
        nextCycle();
        rst = 1'b0;
        modelRdata = '0;
        repeat (25) nextCycle();
        checkOutput("abort_no_resp", 128'(respEdges.size() - resp0), 128'd0);
        checkOutput("abort_rdata_cleared", resp_rdata, modelRdata);
        expLine = {16{8'hFF}};
        for (int i = 0; i < 5; i++) expLine[i*8 +: 8] = line[i*8 +: 8];
        for (int i = 0; i < 16; i++) refMem[20'h00300 + 20'(i)] = expLine[i*8 +: 8];
        checkOutput("abort_mem_line", memLine(20'h00300), refLine(20'h00300));

        // Top line of the address space.
        preloadLine(20'hFFFF0, randLine());
        runTransaction(1'b0, 20'hFFFFA, '0);

        // Random mix of fills and writebacks.
        for (int k = 0; k < 6; k++) begin
            a = 20'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                runTransaction(1'b1, a, randLine());
            end else begin
                preloadLine({a[19:4], 4'h0}, randLine());
                runTransaction(1'b0, a, '0);
            end
        end

        checkOutput("rd_wr_exclusive", 128'(bothCnt), 128'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
